// File: rtl/axi_bresp_tracker_if.sv
// Bundles the observed AW handshake, the B channel and the user response slot of the
// write-response tracker.
interface axi_bresp_tracker_if #(
    parameter int ID_W = 12
);
    logic            m_axi_awvalid;
    logic            m_axi_awready;
    logic [ID_W-1:0] m_axi_awid;
    logic            m_axi_bvalid;
    logic [ID_W-1:0] m_axi_bid;
    logic [1:0]      m_axi_bresp;
    logic            m_axi_bready;
    logic            resp_valid;
    logic            resp_ready;
    logic [ID_W-1:0] resp_id;
    logic [1:0]      resp_code;

    modport slave (
        input  m_axi_awvalid, m_axi_awready, m_axi_awid,
        input  m_axi_bvalid, m_axi_bid, m_axi_bresp, resp_ready,
        output m_axi_bready, resp_valid, resp_id, resp_code
    );

    modport master (
        output m_axi_awvalid, m_axi_awready, m_axi_awid,
        output m_axi_bvalid, m_axi_bid, m_axi_bresp, resp_ready,
        input  m_axi_bready, resp_valid, resp_id, resp_code
    );
endinterface

// File: rtl/axi_bresp_tracker.sv
// AXI B-channel tracker: in-order AWID FIFO, BID/BRESP checking, registered user
// response slot (or drop mode) and sticky error reporting.
module axi_bresp_tracker #(
    parameter int ID_W  = 12,
    parameter int DEPTH = 4,
    parameter int MODE  = 0,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    axi_bresp_tracker_if.slave     bus,
    output logic                   aw_stall,
    output logic [$clog2(DEPTH):0] outstanding,
    output logic                   err_id,
    output logic                   err_resp,
    output logic                   err_unexp,
    output logic                   err_ovf,
    output logic [CNT_W-1:0]       err_cnt,
    input  logic                   err_clr
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [ID_W-1:0]  id_mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [OCC_W-1:0] count_r;
    logic             resp_valid_r;
    logic [ID_W-1:0]  resp_id_r;
    logic [1:0]       resp_code_r;
    logic             err_id_r;
    logic             err_resp_r;
    logic             err_unexp_r;
    logic             err_ovf_r;
    logic [CNT_W-1:0] err_cnt_r;

    logic             aw_fire_s;
    logic             b_fire_s;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;
    logic             bready_s;
    logic             id_evt_s;
    logic             resp_evt_s;
    logic             cnt_evt_s;
    logic             unexp_evt_s;
    logic             ovf_evt_s;
    logic [ID_W-1:0]  head_id_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_W'(1'b1);
        end
    endfunction

    // Handshake decode, FIFO control and error event detection.
    always_comb begin
        full_s      = (count_r == FULL_OCC);
        empty_s     = (count_r == {OCC_W{1'b0}});
        head_id_s   = id_mem_r[rd_ptr_r];
        if (MODE == 0) begin
            bready_s = ~empty_s & (~resp_valid_r | bus.resp_ready);
        end else begin
            bready_s = ~empty_s;
        end
        aw_fire_s   = bus.m_axi_awvalid & bus.m_axi_awready;
        b_fire_s    = bus.m_axi_bvalid & bready_s;
        pop_s       = b_fire_s;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push_s      = aw_fire_s & (~full_s | pop_s);
        ovf_evt_s   = aw_fire_s & full_s & ~pop_s;
        id_evt_s    = b_fire_s & (bus.m_axi_bid != head_id_s);
        resp_evt_s  = b_fire_s & bus.m_axi_bresp[1];
        cnt_evt_s   = id_evt_s | resp_evt_s;
        unexp_evt_s = bus.m_axi_bvalid & empty_s;
    end

    // Outstanding-ID FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                id_mem_r[i] <= {ID_W{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {OCC_W{1'b0}};
        end else begin
            if (push_s) begin
                id_mem_r[wr_ptr_r] <= bus.m_axi_awid;
                wr_ptr_r           <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + OCC_W'(1'b1);
                2'b01:   count_r <= count_r - OCC_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // User response slot; loading and draining together keeps it full with new data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid_r <= 1'b0;
            resp_id_r    <= {ID_W{1'b0}};
            resp_code_r  <= 2'b00;
        end else if ((MODE == 0) && b_fire_s) begin
            resp_valid_r <= 1'b1;
            resp_id_r    <= bus.m_axi_bid;
            resp_code_r  <= bus.m_axi_bresp;
        end else if (bus.resp_ready) begin
            resp_valid_r <= 1'b0;
        end
    end

    // Sticky flags and saturating counter; a same-cycle event beats err_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_id_r    <= 1'b0;
            err_resp_r  <= 1'b0;
            err_unexp_r <= 1'b0;
            err_ovf_r   <= 1'b0;
            err_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            err_id_r    <= (err_clr ? 1'b0 : err_id_r)    | id_evt_s;
            err_resp_r  <= (err_clr ? 1'b0 : err_resp_r)  | resp_evt_s;
            err_unexp_r <= (err_clr ? 1'b0 : err_unexp_r) | unexp_evt_s;
            err_ovf_r   <= (err_clr ? 1'b0 : err_ovf_r)   | ovf_evt_s;
            if (err_clr) begin
                err_cnt_r <= cnt_evt_s ? CNT_W'(1'b1) : {CNT_W{1'b0}};
            end else if (cnt_evt_s) begin
                err_cnt_r <= sat_inc(err_cnt_r);
            end
        end
    end

    assign bus.m_axi_bready = bready_s;
    assign bus.resp_valid   = resp_valid_r;
    assign bus.resp_id      = resp_id_r;
    assign bus.resp_code    = resp_code_r;
    assign aw_stall         = full_s;
    assign outstanding      = count_r;
    assign err_id           = err_id_r;
    assign err_resp         = err_resp_r;
    assign err_unexp        = err_unexp_r;
    assign err_ovf          = err_ovf_r;
    assign err_cnt          = err_cnt_r;
endmodule

// File: tb/tb_axi_bresp_tracker.sv
// Directed bench: instance A (deliver mode, CNT_W=8) is checked through a response
// scoreboard; instance B (drop mode, CNT_W=2) is checked directly.
module tb_axi_bresp_tracker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err_clr_a = 1'b0;
    logic err_clr_b = 1'b0;
    always #5 clk = ~clk;

    axi_bresp_tracker_if #(.ID_W(12)) bus_a ();
    axi_bresp_tracker_if #(.ID_W(12)) bus_b ();

    logic       aw_stall_a, err_id_a, err_resp_a, err_unexp_a, err_ovf_a;
    logic [2:0] outstanding_a;
    logic [7:0] err_cnt_a;
    logic       aw_stall_b, err_id_b, err_resp_b, err_unexp_b, err_ovf_b;
    logic [2:0] outstanding_b;
    logic [1:0] err_cnt_b;

    axi_bresp_tracker #(.ID_W(12), .DEPTH(4), .MODE(0), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave), .aw_stall(aw_stall_a),
        .outstanding(outstanding_a), .err_id(err_id_a), .err_resp(err_resp_a),
        .err_unexp(err_unexp_a), .err_ovf(err_ovf_a), .err_cnt(err_cnt_a),
        .err_clr(err_clr_a)
    );

    axi_bresp_tracker #(.ID_W(12), .DEPTH(4), .MODE(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave), .aw_stall(aw_stall_b),
        .outstanding(outstanding_b), .err_id(err_id_b), .err_resp(err_resp_b),
        .err_unexp(err_unexp_b), .err_ovf(err_ovf_b), .err_cnt(err_cnt_b),
        .err_clr(err_clr_b)
    );

    int checks = 0;
    int errors = 0;
    logic [13:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic aw(input int sel, input logic [11:0] id);
        if (sel == 0) begin
            bus_a.m_axi_awvalid = 1'b1;
            bus_a.m_axi_awid    = id;
        end else begin
            bus_b.m_axi_awvalid = 1'b1;
            bus_b.m_axi_awid    = id;
        end
        @(posedge clk); #1;
        bus_a.m_axi_awvalid = 1'b0;
        bus_b.m_axi_awvalid = 1'b0;
    endtask

    // Holds bvalid until the handshake; the expected user response is queued for A.
    task automatic b_send(input int sel, input logic [11:0] id, input logic [1:0] resp);
        logic got;
        logic rdy;
        got = 1'b0;
        if (sel == 0) begin
            bus_a.m_axi_bvalid = 1'b1; bus_a.m_axi_bid = id; bus_a.m_axi_bresp = resp;
        end else begin
            bus_b.m_axi_bvalid = 1'b1; bus_b.m_axi_bid = id; bus_b.m_axi_bresp = resp;
        end
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            rdy = (sel == 0) ? bus_a.m_axi_bready : bus_b.m_axi_bready;
            if (rdy) begin
                got = 1'b1;
                if (sel == 0) exp_q.push_back({id, resp});
            end
            @(posedge clk); #1;
        end
        bus_a.m_axi_bvalid = 1'b0;
        bus_b.m_axi_bvalid = 1'b0;
        chk("b_handshake", {31'd0, got}, 32'd1);
    endtask

    task automatic clr(input int sel);
        if (sel == 0) err_clr_a = 1'b1; else err_clr_b = 1'b1;
        @(posedge clk); #1;
        err_clr_a = 1'b0;
        err_clr_b = 1'b0;
    endtask

    // Scoreboard monitor: every accepted user response must match the queue head.
    always @(negedge clk) begin
        logic [13:0] e;
        if (!rst && bus_a.resp_valid && bus_a.resp_ready) begin
            chk("sb_avail", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("resp", {18'd0, bus_a.resp_id, bus_a.resp_code}, {18'd0, e});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.m_axi_awvalid = 1'b0; bus_a.m_axi_awready = 1'b1; bus_a.m_axi_awid = 12'h000;
        bus_a.m_axi_bvalid  = 1'b1; bus_a.m_axi_bid     = 12'h000; bus_a.m_axi_bresp = 2'b00;
        bus_a.resp_ready    = 1'b1;
        bus_b.m_axi_awvalid = 1'b0; bus_b.m_axi_awready = 1'b1; bus_b.m_axi_awid = 12'h000;
        bus_b.m_axi_bvalid  = 1'b0; bus_b.m_axi_bid     = 12'h000; bus_b.m_axi_bresp = 2'b00;
        bus_b.resp_ready    = 1'b0;

        // Reset state with bvalid high
        @(posedge clk); #1;
        chk("rst_bready", {31'd0, bus_a.m_axi_bready}, 32'd0);
        chk("rst_outs", {7'd0, bus_a.resp_valid, aw_stall_a, err_id_a, err_resp_a,
                         err_unexp_a, err_ovf_a, outstanding_a, err_cnt_a, bus_a.resp_id},
            32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("unexp_set", {31'd0, err_unexp_a}, 32'd1);
        bus_a.m_axi_bvalid = 1'b0;
        clr(0);
        chk("unexp_clr", {31'd0, err_unexp_a}, 32'd0);

        // Single write
        aw(0, 12'h005);
        chk("single_outs1", {29'd0, outstanding_a}, 32'd1);
        b_send(0, 12'h005, 2'b00);
        chk("single_outs0", {29'd0, outstanding_a}, 32'd0);
        chk("single_latency", {17'd0, bus_a.resp_valid, bus_a.resp_id, bus_a.resp_code},
            {17'd0, 1'b1, 12'h005, 2'b00});
        chk("single_errs", {27'd0, err_id_a, err_resp_a, err_unexp_a, err_ovf_a, 1'b0},
            32'd0);

        // Fill, overflow, drain; three rounds walk the pointers around
        for (int r = 0; r < 3; r++) begin
            for (int k = 1; k <= 4; k++) aw(0, 12'(k));
            chk("fill_stall", {31'd0, aw_stall_a}, 32'd1);
            aw(0, 12'h005);
            chk("ovf_flag", {31'd0, err_ovf_a}, 32'd1);
            chk("ovf_count", {29'd0, outstanding_a}, 32'd4);
            for (int k = 1; k <= 4; k++) b_send(0, 12'(k), 2'b00);
            chk("drain_count", {29'd0, outstanding_a}, 32'd0);
            chk("drain_noerr", {30'd0, err_id_a, aw_stall_a}, 32'd0);
            clr(0);
        end

        // Backpressure on the user side
        aw(0, 12'h021);
        aw(0, 12'h022);
        bus_a.resp_ready = 1'b0;
        b_send(0, 12'h021, 2'b00);
        bus_a.m_axi_bvalid = 1'b1; bus_a.m_axi_bid = 12'h022; bus_a.m_axi_bresp = 2'b01;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("bp_bready", {31'd0, bus_a.m_axi_bready}, 32'd0);
            chk("bp_hold", {17'd0, bus_a.resp_valid, bus_a.resp_id, bus_a.resp_code},
                {17'd0, 1'b1, 12'h021, 2'b00});
            @(posedge clk); #1;
        end
        bus_a.resp_ready = 1'b1;
        b_send(0, 12'h022, 2'b01);
        chk("bp_b2b", {19'd0, bus_a.resp_valid, bus_a.resp_id}, {19'd0, 1'b1, 12'h022});

        // Error reporting
        aw(0, 12'h009);
        b_send(0, 12'h00A, 2'b00);
        chk("err_id", {31'd0, err_id_a}, 32'd1);
        chk("err_cnt1", {24'd0, err_cnt_a}, 32'd1);
        aw(0, 12'h007);
        b_send(0, 12'h007, 2'b10);
        chk("err_resp", {31'd0, err_resp_a}, 32'd1);
        chk("err_cnt2", {24'd0, err_cnt_a}, 32'd2);
        clr(0);
        chk("err_clr", {20'd0, err_id_a, err_resp_a, err_unexp_a, err_ovf_a, err_cnt_a},
            32'd0);
        aw(0, 12'h003);
        err_clr_a = 1'b1;
        b_send(0, 12'h004, 2'b00);
        err_clr_a = 1'b0;
        chk("clr_evt_wins", {23'd0, err_id_a, err_cnt_a}, {23'd0, 1'b1, 8'd1});
        clr(0);
        aw(0, 12'h001);
        b_send(0, 12'h002, 2'b11);
        chk("double_err", {22'd0, err_id_a, err_resp_a, err_cnt_a}, {22'd0, 2'b11, 8'd1});
        clr(0);

        // Drop mode and small saturating counter
        aw(1, 12'h011); aw(1, 12'h012); aw(1, 12'h013);
        for (int k = 0; k < 3; k++) b_send(1, 12'(8'h11 + k), 2'b00);
        chk("m1_valid", {31'd0, bus_b.resp_valid}, 32'd0);
        chk("m1_outs", {29'd0, outstanding_b}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            aw(1, 12'h030);
            b_send(1, 12'h030, 2'b10);
        end
        chk("m1_sat", {29'd0, err_resp_b, err_cnt_b}, {29'd0, 1'b1, 2'd3});

        // Asynchronous reset in the middle of a burst
        for (int k = 0; k < 5; k++) aw(0, 12'(8'h41 + k));
        bus_a.resp_ready = 1'b0;
        b_send(0, 12'h041, 2'b00);
        aw(0, 12'h046);
        #2 rst = 1'b1;
        #1;
        chk("arst_state", {24'd0, bus_a.resp_valid, aw_stall_a, err_ovf_a, err_id_a,
                           outstanding_a, 1'b0}, 32'd0);
        chk("arst_cnt_b", {30'd0, err_cnt_b}, 32'd0);
        @(posedge clk); #1;
        exp_q.delete();
        rst = 1'b0;
        bus_a.resp_ready = 1'b1;
        aw(0, 12'h050);
        b_send(0, 12'h050, 2'b00);
        chk("post_rst", {28'd0, err_id_a, err_ovf_a, outstanding_a[1:0]}, 32'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
